// File: rtl/sincos_nco_scheduler.sv
// sincos_nco_scheduler: multi-channel NCO front end that time-shares one
// fixed-latency sine core. It keeps one phase accumulator per channel, issues
// phases in round-robin slots, and tags each issue so that core results come
// back labelled with their channel.
// Optional build macro SINCOS_SCHED_COS_EN: each channel takes two slots
// (sine, then cosine as a quarter-turn offset), and out_cos_o marks the
// cosine result.
module sincos_nco_scheduler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_BITS    = $clog2(NUM_CH),
  parameter int unsigned PHASE_BITS = 47,
  parameter int unsigned OUT_BITS   = 56,
  parameter int unsigned CORE_LAT   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run_i,
  input  logic                  sync_i,
  input  logic [NUM_CH-1:0]     ch_en_i,
  input  logic                  cfg_we_i,
  input  logic                  cfg_sel_i,
  input  logic [CH_BITS-1:0]    cfg_ch_i,
  input  logic [PHASE_BITS-1:0] cfg_data_i,
  output logic                  core_valid_o,
  output logic [PHASE_BITS-1:0] core_phase_o,
  input  logic                  core_valid_i,
  input  logic [OUT_BITS-1:0]   core_y_i,
  output logic                  out_valid_o,
  output logic [CH_BITS-1:0]    out_ch_o,
  output logic                  out_cos_o,
  output logic [OUT_BITS-1:0]   out_y_o,
  output logic                  err_o
);

`ifdef SINCOS_SCHED_COS_EN
  localparam int unsigned PTR_BITS = CH_BITS + 1;
`else
  localparam int unsigned PTR_BITS = CH_BITS;
`endif

  localparam logic [PHASE_BITS-1:0] QTR_TURN = {2'b01, {(PHASE_BITS-2){1'b0}}};

  logic [PTR_BITS-1:0]   r_ptr;
  logic [PHASE_BITS-1:0] r_acc [NUM_CH];
  logic [PHASE_BITS-1:0] r_fcw [NUM_CH];
  logic [PHASE_BITS-1:0] r_off [NUM_CH];

  logic [CH_BITS-1:0]    w_ch;
  logic                  w_cos;
  logic                  w_step;
  logic                  w_issue;
  logic                  w_fire;
  logic [PHASE_BITS-1:0] w_base;
  logic [PHASE_BITS-1:0] w_phase;

  // Registered copy of the issued slot's label; together with core_valid_o it
  // forms the entry point of the tag line, so the last tag stage lines up with
  // the cycle in which the core presents the matching result.
  logic [CH_BITS-1:0]    r_iss_ch;
  logic                  r_tag_v  [CORE_LAT];
  logic [CH_BITS-1:0]    r_tag_ch [CORE_LAT];
`ifdef SINCOS_SCHED_COS_EN
  logic                  r_iss_cos;
  logic                  r_tag_cos [CORE_LAT];
`endif

  // Decode the current slot into channel, sine/cosine half and issue phase.
  always_comb begin
`ifdef SINCOS_SCHED_COS_EN
    w_ch   = r_ptr[PTR_BITS-1:1];
    w_cos  = r_ptr[0];
    w_step = r_ptr[0];
`else
    w_ch   = r_ptr;
    w_cos  = 1'b0;
    w_step = 1'b1;
`endif
    w_base  = r_acc[w_ch] + r_off[w_ch];
    w_phase = w_base + (w_cos ? QTR_TURN : '0);
    w_issue = run_i & ~sync_i;
    w_fire  = w_issue & ch_en_i[w_ch];
  end

  // Frequency and offset registers; a write lands at the edge, so an issue in
  // the same cycle still sees the old value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_fcw[i] <= '0;
        r_off[i] <= '0;
      end
    end else if (cfg_we_i) begin
      if (cfg_sel_i) r_off[cfg_ch_i] <= cfg_data_i;
      else           r_fcw[cfg_ch_i] <= cfg_data_i;
    end
  end

  // Slot pointer and accumulators; disabled slots still advance the phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (sync_i) begin
      r_ptr <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (run_i) begin
      r_ptr <= r_ptr + PTR_BITS'(1);
      if (w_step) r_acc[w_ch] <= r_acc[w_ch] + r_fcw[w_ch];
    end
  end

  // Issue port towards the core; the phase holds between valid issues.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_valid_o <= 1'b0;
      core_phase_o <= '0;
      r_iss_ch     <= '0;
    end else begin
      core_valid_o <= w_fire;
      r_iss_ch     <= w_ch;
      if (w_fire) core_phase_o <= w_phase;
    end
  end

`ifdef SINCOS_SCHED_COS_EN
  // Sine/cosine label of the issued slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_iss_cos <= 1'b0;
    else         r_iss_cos <= w_cos;
  end
`endif

  // Latency-matched tag line following the core pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < CORE_LAT; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_ch[k] <= '0;
      end
    end else begin
      r_tag_v[0]  <= core_valid_o;
      r_tag_ch[0] <= r_iss_ch;
      for (int unsigned k = 1; k < CORE_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_ch[k] <= r_tag_ch[k-1];
      end
    end
  end

`ifdef SINCOS_SCHED_COS_EN
  // Cosine flag travelling alongside the channel tag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < CORE_LAT; k++) r_tag_cos[k] <= 1'b0;
    end else begin
      r_tag_cos[0] <= r_iss_cos;
      for (int unsigned k = 1; k < CORE_LAT; k++) r_tag_cos[k] <= r_tag_cos[k-1];
    end
  end
`endif

  // Result register: pass the core sample through with its tag, and flag any
  // disagreement between expected and actual core valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      out_y_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      out_valid_o <= core_valid_i;
      out_y_o     <= core_y_i;
      out_ch_o    <= r_tag_ch[CORE_LAT-1];
      if (r_tag_v[CORE_LAT-1] != core_valid_i) err_o <= 1'b1;
    end
  end

`ifdef SINCOS_SCHED_COS_EN
  // Cosine label of the returned sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_cos_o <= 1'b0;
    else         out_cos_o <= r_tag_cos[CORE_LAT-1];
  end
`else
  assign out_cos_o = 1'b0;
`endif

endmodule

// File: tb/tb_sincos_nco_scheduler.sv
// Bench for sincos_nco_scheduler: a 5-cycle core stand-in plus a slot-level
// reference model of the scheduler; every cycle the issue port, the error
// flag and the tagged result stream are compared against the model.
module tb_sincos_nco_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_BITS = 2;
  localparam int PB = 47;
  localparam int OB = 56;
  localparam int LAT = 5;
`ifdef SINCOS_SCHED_COS_EN
  localparam bit COS_EN = 1'b1;
`else
  localparam bit COS_EN = 1'b0;
`endif
  localparam int NSLOT = COS_EN ? 2 * NUM_CH : NUM_CH;
  localparam longint unsigned MASK = (64'd1 << PB) - 64'd1;
  localparam longint unsigned QTR  = 64'd1 << (PB - 2);

  logic              clk = 1'b0;
  logic              resetn;
  logic              run_i, sync_i, cfg_we_i, cfg_sel_i;
  logic [NUM_CH-1:0] ch_en_i;
  logic [CH_BITS-1:0] cfg_ch_i;
  logic [PB-1:0]     cfg_data_i;
  logic              core_valid_o;
  logic [PB-1:0]     core_phase_o;
  logic              core_valid_i;
  logic [OB-1:0]     core_y_i;
  logic              out_valid_o;
  logic [CH_BITS-1:0] out_ch_o;
  logic              out_cos_o;
  logic [OB-1:0]     out_y_o;
  logic              err_o;

  sincos_nco_scheduler #(
    .NUM_CH(NUM_CH), .PHASE_BITS(PB), .OUT_BITS(OB), .CORE_LAT(LAT)
  ) u_dut (
    .clk(clk), .resetn(resetn), .run_i(run_i), .sync_i(sync_i),
    .ch_en_i(ch_en_i), .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i),
    .cfg_ch_i(cfg_ch_i), .cfg_data_i(cfg_data_i),
    .core_valid_o(core_valid_o), .core_phase_o(core_phase_o),
    .core_valid_i(core_valid_i), .core_y_i(core_y_i),
    .out_valid_o(out_valid_o), .out_ch_o(out_ch_o), .out_cos_o(out_cos_o),
    .out_y_o(out_y_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Core stand-in: 5 register stages, sample is a fixed scramble of the phase.
  function automatic logic [OB-1:0] core_fn(input logic [PB-1:0] p);
    return {p, 9'h0} ^ {9'h0, ~p};
  endfunction

  logic          pv [LAT];
  logic [PB-1:0] pp [LAT];
  logic          force_v = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < LAT; k++) begin pv[k] <= 1'b0; pp[k] <= '0; end
    end else begin
      pv[0] <= core_valid_o;
      pp[0] <= core_phase_o;
      for (int k = 1; k < LAT; k++) begin pv[k] <= pv[k-1]; pp[k] <= pp[k-1]; end
    end
  end

  assign core_valid_i = pv[LAT-1] | force_v;
  assign core_y_i     = core_fn(pp[LAT-1]);

  // Reference model state
  typedef struct {
    int              due;
    int              ch;
    bit              cos;
    longint unsigned ph;
  } exp_t;

  longint unsigned m_acc [NUM_CH];
  longint unsigned m_fcw [NUM_CH];
  longint unsigned m_off [NUM_CH];
  int              m_slot;
  bit              m_err;
  bit              m_cv;
  longint unsigned m_ph;
  exp_t            q[$];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin m_acc[i] = 0; m_fcw[i] = 0; m_off[i] = 0; end
    m_slot = 0; m_err = 0; m_cv = 0; m_ph = 0;
    q.delete();
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step();
    bit              forced;
    bit              exp_ov;
    int              c;
    bit              cs;
    longint unsigned p;
    exp_t            e;
    forced = 1'b0;
    if (!resetn) begin
      model_clear();
    end else begin
      m_cv = 1'b0;
      if (sync_i) begin
        for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
        m_slot = 0;
      end else if (run_i) begin
        c  = COS_EN ? m_slot / 2 : m_slot;
        cs = COS_EN ? m_slot[0] : 1'b0;
        p  = (m_acc[c] + m_off[c]) & MASK;
        if (cs) p = (p + QTR) & MASK;
        if (ch_en_i[c]) begin
          m_cv = 1'b1;
          m_ph = p;
          q.push_back('{due: cyc + 1 + LAT + 1, ch: c, cos: cs, ph: p});
        end
        if (!COS_EN || cs) m_acc[c] = (m_acc[c] + m_fcw[c]) & MASK;
        m_slot = (m_slot + 1) % NSLOT;
      end
      if (cfg_we_i) begin
        if (cfg_sel_i) m_off[cfg_ch_i] = 64'(cfg_data_i);
        else           m_fcw[cfg_ch_i] = 64'(cfg_data_i);
      end
      if (force_v) begin m_err = 1'b1; forced = 1'b1; end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("core_valid", 64'(core_valid_o), 64'(m_cv));
    check_eq("core_phase", 64'(core_phase_o), m_ph);
    check_eq("err", 64'(err_o), 64'(m_err));
    if (forced) begin
      check_eq("out_valid_forced", 64'(out_valid_o), 64'd1);
    end else begin
      exp_ov = (q.size() > 0) && (q[0].due == cyc);
      check_eq("out_valid", 64'(out_valid_o), 64'(exp_ov));
      if (exp_ov) begin
        e = q.pop_front();
        check_eq("out_ch", 64'(out_ch_o), 64'(e.ch));
        check_eq("out_cos", 64'(out_cos_o), 64'(e.cos));
        check_eq("out_y", 64'(out_y_o), 64'(core_fn(PB'(e.ph))));
      end
    end
  endtask

  task automatic cfg_write(input bit sel, input int ch, input longint unsigned data);
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_ch_i   = CH_BITS'(ch);
    cfg_data_i = PB'(data);
    step();
    cfg_we_i   = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync_pulse();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; run_i = 1'b1; sync_i = 1'b0; ch_en_i = '1;
    cfg_we_i = 1'b0; cfg_sel_i = 1'b0; cfg_ch_i = '0; cfg_data_i = '0;
    model_clear();

    // Reset held with run and enables active: everything stays at zero
    run_cycles(3);
    check_eq("rst_out_y", 64'(out_y_o), 64'd0);
    check_eq("rst_out_ch", 64'(out_ch_o), 64'd0);
    check_eq("rst_out_cos", 64'(out_cos_o), 64'd0);
    #2 resetn = 1'b1;
    run_i = 1'b0;

    // Single channel stepping by 2^40
    ch_en_i = 4'b0001;
    cfg_write(1'b0, 0, 64'd1 << 40);
    sync_pulse();
    run_i = 1'b1;
    run_cycles(30);

    // Round robin over all channels, fcw = c+1, off[2] = 2^45
    run_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) cfg_write(1'b0, c, 64'(c + 1));
    cfg_write(1'b1, 2, 64'd1 << 45);
    ch_en_i = '1;
    sync_pulse();
    run_i = 1'b1;
    run_cycles(20);

    // FCW write colliding with channel 1's (last) slot
    run_i = 1'b0;
    cfg_write(1'b0, 1, 64'd7);
    sync_pulse();
    run_i = 1'b1;
    for (int i = 0; i < NSLOT && m_slot != (COS_EN ? 3 : 1); i++) step();
    check_eq("collision_slot", 64'(m_slot), COS_EN ? 64'd3 : 64'd1);
    cfg_write(1'b0, 1, 64'd100);
    run_cycles(3 * NSLOT);

    // Sync mid-stream, then a 3-cycle pause
    run_cycles(5);
    sync_pulse();
    run_cycles(6);
    run_i = 1'b0;
    run_cycles(3);
    run_i = 1'b1;
    run_cycles(10);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      run_i    = ($urandom % 8) != 0;
      sync_i   = ($urandom % 40) == 0;
      ch_en_i  = NUM_CH'($urandom);
      cfg_we_i = ($urandom % 4) == 0;
      cfg_sel_i = $urandom % 2;
      cfg_ch_i = CH_BITS'($urandom);
      cfg_data_i = PB'({$urandom, $urandom});
      step();
    end
    sync_i = 1'b0; cfg_we_i = 1'b0; run_i = 1'b1; ch_en_i = '1;
    run_cycles(4);

    // Reset mid-operation drops in-flight work and configuration
    resetn = 1'b0;
    run_cycles(2);
    resetn = 1'b1;
    cfg_write(1'b0, 3, 64'h1234_5678);
    cfg_write(1'b1, 0, 64'h5_0000_0000);
    run_cycles(16);

    // Drain, then force a spurious core valid with an empty tag line
    run_i = 1'b0;
    run_cycles(10);
    check_eq("drained", 64'(q.size()), 64'd0);
    force_v = 1'b1;
    step();
    force_v = 1'b0;
    run_cycles(3);
    check_eq("err_sticky", 64'(err_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
